rsa_uart_cmd_wrapper: RTL and testbench

- Parametrised Avalon-MM master that connects a UART-style RX/TX/STATUS register slave to an external modular-exponentiation core.
- Adds a command-byte protocol on top of the fixed N/D/data sequence:
  - keys reload at run time without reset;
  - data blocks are rejected until a key is loaded;
  - operand width and reply length are configurable.
- Sits between the qsys UART bridge and Rsa256Core, or a wider/narrower core variant.

---
 rtl/rsa_uart_cmd_wrapper_if.sv | 19 +
 rtl/rsa_uart_cmd_wrapper.sv | 214 +++++++++++++++++++++
 tb/tb_rsa_uart_cmd_wrapper.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_uart_cmd_wrapper_if.sv
// Avalon-MM bus between the command wrapper (master) and the UART register slave.
interface rsa_uart_cmd_wrapper_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/rsa_uart_cmd_wrapper.sv
// Command-byte front end: pulls keys/ciphertext from a UART register slave,
// drives a modexp core and streams the result back out over TX.
module rsa_uart_cmd_wrapper #(
    parameter int         BITWIDTH  = 256,
    parameter int         OUT_BYTES = BITWIDTH/8-1,
    parameter logic [7:0] CMD_KEY   = 8'h4B,
    parameter logic [7:0] CMD_DATA  = 8'h44
) (
    input  logic                  avm_clk,
    input  logic                  avm_rst,
    rsa_uart_cmd_wrapper_if.master avm,
    output logic                  core_start,
    output logic [BITWIDTH-1:0]   core_a,
    output logic [BITWIDTH-1:0]   core_d,
    output logic [BITWIDTH-1:0]   core_n,
    input  logic [BITWIDTH-1:0]   core_result,
    input  logic                  core_finished,
    output logic                  key_valid,
    output logic [7:0]            bad_cmd_cnt,
    output logic [15:0]           block_cnt
);
    localparam int NB = BITWIDTH/8;
    localparam int CW = $clog2(NB)+1;

    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    typedef enum logic [2:0] {
        S_CMD, S_GET_N, S_GET_D, S_GET_A, S_REQ, S_WAIT, S_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          addr_q, addr_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                start_q, start_d;
    logic [BITWIDTH-1:0] n_q, n_d, d_q, d_d, a_q, a_d, res_q, res_d;
    logic                kv_q, kv_d;
    logic [7:0]          bad_q, bad_d;
    logic [15:0]         blk_q, blk_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic       done, st_done, rx_done, tx_done;
    logic [7:0] rx_byte;
    logic       unused_rdata;

    assign rx_byte      = avm.avm_readdata[7:0];
    assign unused_rdata = ^avm.avm_readdata[31:8];
    assign done         = (read_q | write_q) & ~avm.avm_waitrequest;
    assign st_done      = done && (addr_q == ADDR_STATUS);
    assign rx_done      = done && (addr_q == ADDR_RX);
    assign tx_done      = done && (addr_q == ADDR_TX);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        n_d     = n_q;
        d_d     = d_q;
        a_d     = a_q;
        res_d   = res_q;
        kv_d    = kv_q;
        bad_d   = bad_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_CMD, S_GET_N, S_GET_D, S_GET_A: begin
                // Shared receive engine: poll STATUS until RX ready, then read RX once.
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = ADDR_STATUS;
                end
                if (st_done && avm.avm_readdata[7]) addr_d = ADDR_RX;
                if (rx_done) begin
                    addr_d = ADDR_STATUS;
                    cnt_d  = cnt_q + 1'b1;
                    case (state_q)
                        S_CMD: begin
                            cnt_d = '0;
                            if (rx_byte == CMD_KEY) begin
                                state_d = S_GET_N;
                                kv_d    = 1'b0;
                            end else if (rx_byte == CMD_DATA && kv_q) begin
                                state_d = S_GET_A;
                            end else if (bad_q != 8'hFF) begin
                                bad_d = bad_q + 8'd1;
                            end
                        end
                        S_GET_N: begin
                            n_d = {n_q[BITWIDTH-9:0], rx_byte};
                            if (cnt_q == CW'(NB-1)) begin
                                state_d = S_GET_D;
                                cnt_d   = '0;
                            end
                        end
                        S_GET_D: begin
                            d_d = {d_q[BITWIDTH-9:0], rx_byte};
                            if (cnt_q == CW'(NB-1)) begin
                                state_d = S_CMD;
                                kv_d    = 1'b1;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            a_d = {a_q[BITWIDTH-9:0], rx_byte};
                            if (cnt_q == CW'(NB-1)) begin
                                state_d = S_REQ;
                                read_d  = 1'b0;
                                cnt_d   = '0;
                            end
                        end
                    endcase
                end
            end
            S_REQ: begin
                start_d = 1'b1;
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                if (core_finished) begin
                    res_d   = core_result;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!read_q && !write_q) begin
                    read_d = 1'b1;
                    addr_d = ADDR_STATUS;
                end
                if (st_done && avm.avm_readdata[6]) begin
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = ADDR_TX;
                    wdata_d = res_q[OUT_BYTES*8-1 -: 8];
                end
                if (tx_done) begin
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    addr_d  = ADDR_STATUS;
                    res_d   = res_q << 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(OUT_BYTES-1)) begin
                        state_d = S_CMD;
                        cnt_d   = '0;
                        blk_d   = blk_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_CMD;
                read_d  = 1'b0;
                write_d = 1'b0;
                addr_d  = ADDR_STATUS;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q <= S_CMD;
            addr_q  <= ADDR_STATUS;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            start_q <= 1'b0;
            n_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            res_q   <= '0;
            kv_q    <= 1'b0;
            bad_q   <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            n_q     <= n_d;
            d_q     <= d_d;
            a_q     <= a_d;
            res_q   <= res_d;
            kv_q    <= kv_d;
            bad_q   <= bad_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign avm.avm_address   = addr_q;
    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_writedata = {24'b0, wdata_q};
    assign core_start        = start_q;
    assign core_a            = a_q;
    assign core_d            = d_q;
    assign core_n            = n_q;
    assign key_valid         = kv_q;
    assign bad_cmd_cnt       = bad_q;
    assign block_cnt         = blk_q;
endmodule

// File: tb/tb_rsa_uart_cmd_wrapper.sv
// Bench: UART register slave + modexp core stand-in, scoreboarded TX bytes and core operands.
module tb_rsa_uart_cmd_wrapper;
    localparam int BW = 16;
    localparam int OB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_start, core_finished, key_valid;
    logic [BW-1:0] core_a, core_d, core_n, core_result;
    logic [7:0]    bad_cmd_cnt;
    logic [15:0]   block_cnt;

    rsa_uart_cmd_wrapper_if bus();

    rsa_uart_cmd_wrapper #(.BITWIDTH(BW), .OUT_BYTES(OB)) dut (
        .avm_clk(clk), .avm_rst(rst), .avm(bus),
        .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished),
        .key_valid(key_valid), .bad_cmd_cnt(bad_cmd_cnt), .block_cnt(block_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [47:0] exp_start[$];
    int checks = 0, errors = 0;
    int waits_cfg = 0, nr_cfg = 0, nr_left = 0, stall = 0, pend = 0;
    int n_starts = 0, n_tx = 0, n_rxrd = 0;
    bit in_txn = 0, last_st7 = 0, prev_stall = 0, core_auto = 1, force_fin = 0;
    logic [38:0] snap;
    logic [BW-1:0] res_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [BW-1:0] modexp(input logic [BW-1:0] a, input logic [BW-1:0] d,
                                             input logic [BW-1:0] n);
        logic [31:0] r, b;
        if (n == '0) return '0;
        r = 32'd1;
        b = 32'(a) % 32'(n);
        for (int i = BW-1; i >= 0; i--) begin
            r = (r * r) % 32'(n);
            if (d[i]) r = (r * b) % 32'(n);
        end
        return r[BW-1:0];
    endfunction

    task automatic slave_complete();
        logic st7;
        if (bus.avm_read && bus.avm_address == 5'd8) begin
            st7 = (rx_q.size() > 0) && (nr_left == 0);
            if (rx_q.size() > 0 && nr_left > 0) nr_left--;
            bus.avm_readdata = {24'b0, st7, 1'b1, 6'b0};
            last_st7 = st7;
        end else if (bus.avm_read && bus.avm_address == 5'd0) begin
            chk("rx_read_after_ready", 64'(last_st7), 64'd1);
            if (rx_q.size() == 0) fail("rx_read_with_empty_fifo");
            else bus.avm_readdata = {24'b0, rx_q.pop_front()};
            n_rxrd++;
            nr_left  = nr_cfg;
            last_st7 = 1'b0;
        end else if (bus.avm_write && bus.avm_address == 5'd4) begin
            n_tx++;
            if (exp_tx.size() == 0) fail("unexpected_tx_write");
            else chk("tx_byte", 64'(bus.avm_writedata), 64'({24'b0, exp_tx.pop_front()}));
        end else begin
            fail("bad_bus_access");
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            core_finished = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (core_start) begin
                n_starts++;
                if (exp_start.size() == 0) fail("unexpected_core_start");
                else chk("core_operands", 64'({core_a, core_d, core_n}), 64'(exp_start.pop_front()));
                if (core_auto) begin
                    pend  = 4;
                    res_m = modexp(core_a, core_d, core_n);
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_result   = res_m;
                    core_finished = 1'b1;
                end
            end
            if (force_fin) begin
                core_result   = 16'h0020;
                core_finished = 1'b1;
                force_fin     = 1'b0;
            end
            if (prev_stall)
                chk("stall_hold", 64'({bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata}),
                    64'(snap));
            prev_stall = 1'b0;
            if (rst) begin
                in_txn = 1'b0;
                stall  = 0;
                bus.avm_waitrequest = 1'b0;
            end else if (bus.avm_read || bus.avm_write) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    stall  = waits_cfg;
                end
                if (stall > 0) begin
                    stall--;
                    bus.avm_waitrequest = 1'b1;
                    prev_stall = 1'b1;
                    snap = {bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata};
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    in_txn = 1'b0;
                    slave_complete();
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_txn = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_key(input logic [15:0] n, input logic [15:0] d);
        rx_q.push_back(8'h4B);
        rx_q.push_back(n[15:8]); rx_q.push_back(n[7:0]);
        rx_q.push_back(d[15:8]); rx_q.push_back(d[7:0]);
    endtask

    task automatic send_block(input logic [15:0] a, input logic [47:0] ops, input logic [15:0] res);
        exp_start.push_back(ops);
        exp_tx.push_back(res[15:8]);
        exp_tx.push_back(res[7:0]);
        rx_q.push_back(8'h44);
        rx_q.push_back(a[15:8]); rx_q.push_back(a[7:0]);
    endtask

    task automatic wait_blocks(input int n, input string name);
        int t = 0;
        while (block_cnt != 16'(n) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(block_cnt), 64'(n));
        chk({name, "_tx_drained"}, 64'(exp_tx.size()), 64'd0);
    endtask

    task automatic wait_key();
        int t = 0;
        while (!key_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("key_valid_set", 64'(key_valid), 64'd1);
    endtask

    task automatic wait_rx_drained();
        int t = 0;
        while (rx_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rx_drained", 64'(rx_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int tx0, st0, t;
        rst = 1'b1;
        core_finished = 1'b0;
        core_result   = '0;
        bus.avm_readdata    = '0;
        bus.avm_waitrequest = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_address", 64'(bus.avm_address), 64'd8);
        chk("rst_rd_wr", 64'({bus.avm_read, bus.avm_write}), 64'd0);
        chk("rst_writedata", 64'(bus.avm_writedata), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_key_valid", 64'(key_valid), 64'd0);
        chk("rst_counters", 64'({bad_cmd_cnt, block_cnt}), 64'd0);
        chk("rst_keys", 64'({core_n, core_d, core_a}), 64'd0);
        rst = 1'b0;

        // zero-wait key load then one block
        send_key(16'h0021, 16'h0005);
        wait_key();
        chk("rx_reads_at_key_valid", 64'(n_rxrd), 64'd5);
        chk("core_n", 64'(core_n), 64'h0021);
        chk("core_d", 64'(core_d), 64'h0005);
        send_block(16'h0002, {16'h0002, 16'h0005, 16'h0021}, 16'h0020);
        wait_blocks(1, "block_cnt_basic");
        chk("starts_basic", 64'(n_starts), 64'd1);
        chk("bad_cmd_basic", 64'(bad_cmd_cnt), 64'd0);

        // data without key and an unknown command are both rejected
        do_reset();
        rx_q.push_back(8'h44);
        rx_q.push_back(8'h7A);
        wait_rx_drained();
        chk("bad_cmd_cnt", 64'(bad_cmd_cnt), 64'd2);
        chk("key_valid_after_bad", 64'(key_valid), 64'd0);
        chk("no_start_on_bad", 64'(n_starts), 64'd1);
        chk("no_tx_on_bad", 64'(n_tx), 64'd2);

        // three-cycle waitrequest on every access
        do_reset();
        waits_cfg = 3;
        send_key(16'h0021, 16'h0005);
        send_block(16'h0002, {16'h0002, 16'h0005, 16'h0021}, 16'h0020);
        wait_blocks(1, "block_cnt_stall1");
        send_block(16'h0003, {16'h0003, 16'h0005, 16'h0021}, 16'h000C);
        wait_blocks(2, "block_cnt_stall2");
        chk("tx_count_stall", 64'(n_tx), 64'd6);

        // ten not-ready polls before each byte, plus a key reload
        do_reset();
        waits_cfg = 0;
        nr_cfg  = 10;
        nr_left = 10;
        send_key(16'h0021, 16'h0005);
        send_block(16'h0007, {16'h0007, 16'h0005, 16'h0021}, 16'h000A);
        wait_blocks(1, "block_cnt_poll1");
        send_key(16'h0023, 16'h0003);
        send_block(16'h0004, {16'h0004, 16'h0003, 16'h0023}, 16'h001D);
        wait_blocks(2, "block_cnt_reload");
        chk("reloaded_n", 64'(core_n), 64'h0023);
        chk("reloaded_d", 64'(core_d), 64'h0003);

        // reset while the core is computing; the late finish must be ignored
        do_reset();
        nr_cfg  = 0;
        nr_left = 0;
        core_auto = 1'b0;
        st0 = n_starts;
        send_key(16'h0021, 16'h0005);
        exp_start.push_back({16'h0002, 16'h0005, 16'h0021});
        rx_q.push_back(8'h44); rx_q.push_back(8'h00); rx_q.push_back(8'h02);
        t = 0;
        while (n_starts == st0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("start_before_abort", 64'(n_starts), 64'(st0 + 1));
        repeat (2) @(negedge clk);
        tx0 = n_tx;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_address", 64'(bus.avm_address), 64'd8);
        chk("abort_rd_wr_start", 64'({bus.avm_read, bus.avm_write, core_start}), 64'd0);
        chk("abort_key_valid", 64'(key_valid), 64'd0);
        chk("abort_operands", 64'({core_a, core_d, core_n}), 64'd0);
        rst = 1'b0;
        force_fin = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_tx", 64'(n_tx), 64'(tx0));
        chk("abort_block_cnt", 64'(block_cnt), 64'd0);
        chk("abort_key_still_invalid", 64'(key_valid), 64'd0);
        chk("abort_no_restart", 64'(n_starts), 64'(st0 + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
